// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and segment constants for the multiplexed 7-segment driver.
package seg7_scan_driver_pkg;

  `include "seg7_defs.vh"

  typedef logic [SEG_W-1:0] seg_pat_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to active-low segment pattern; codes 10-15 show
// hex letters only when hex_en is set, otherwise they are dark.
module seg7_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_en,
  input  logic       blank,
  output seg_pat_t   pattern
);

  // code lookup with forced-blank override
  always_comb begin
    pattern = SEG_BLANK;
    if (blank) begin
      pattern = SEG_BLANK;
    end else begin
      case (code)
        4'h0:    pattern = SEG_PAT_0;
        4'h1:    pattern = SEG_PAT_1;
        4'h2:    pattern = SEG_PAT_2;
        4'h3:    pattern = SEG_PAT_3;
        4'h4:    pattern = SEG_PAT_4;
        4'h5:    pattern = SEG_PAT_5;
        4'h6:    pattern = SEG_PAT_6;
        4'h7:    pattern = SEG_PAT_7;
        4'h8:    pattern = SEG_PAT_8;
        4'h9:    pattern = SEG_PAT_9;
        4'hA:    pattern = hex_en ? SEG_PAT_A : SEG_BLANK;
        4'hB:    pattern = hex_en ? SEG_PAT_B : SEG_BLANK;
        4'hC:    pattern = hex_en ? SEG_PAT_C : SEG_BLANK;
        4'hD:    pattern = hex_en ? SEG_PAT_D : SEG_BLANK;
        4'hE:    pattern = hex_en ? SEG_PAT_E : SEG_BLANK;
        4'hF:    pattern = hex_en ? SEG_PAT_F : SEG_BLANK;
        default: pattern = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_defs.vh
// Segment pattern constants for the 7-segment scan driver.
// All patterns are active-low in {g,f,e,d,c,b,a} order (bit 0 = segment a).
`ifndef SEG7_DEFS_VH
`define SEG7_DEFS_VH

localparam int SEG_W = 7;

localparam logic [6:0] SEG_PAT_0 = 7'b1000000;
localparam logic [6:0] SEG_PAT_1 = 7'b1111001;
localparam logic [6:0] SEG_PAT_2 = 7'b0100100;
localparam logic [6:0] SEG_PAT_3 = 7'b0110000;
localparam logic [6:0] SEG_PAT_4 = 7'b0011001;
localparam logic [6:0] SEG_PAT_5 = 7'b0010010;
localparam logic [6:0] SEG_PAT_6 = 7'b0000010;
localparam logic [6:0] SEG_PAT_7 = 7'b1111000;
localparam logic [6:0] SEG_PAT_8 = 7'b0000000;
localparam logic [6:0] SEG_PAT_9 = 7'b0010000;
localparam logic [6:0] SEG_PAT_A = 7'b0001000;
localparam logic [6:0] SEG_PAT_B = 7'b0000011;
localparam logic [6:0] SEG_PAT_C = 7'b1000110;
localparam logic [6:0] SEG_PAT_D = 7'b0100001;
localparam logic [6:0] SEG_PAT_E = 7'b0000110;
localparam logic [6:0] SEG_PAT_F = 7'b0001110;
localparam logic [6:0] SEG_BLANK = 7'b1111111;

`endif

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with a frame-synchronous
// double buffer, optional hex decode, decimal points and leading-zero blanking.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000,
  parameter int HEX_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   code_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_blank,
  input  logic                  enable,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic             HEX_EN   = (HEX_MODE != 0);

  logic [DIV_W-1:0]    div_r;
  logic [IDX_W-1:0]    idx_r;
  logic [4*DIGITS-1:0] active_code_r;
  logic [DIGITS-1:0]   active_dp_r;
  logic [4*DIGITS-1:0] pend_code_r;
  logic [DIGITS-1:0]   pend_dp_r;
  logic                pend_r;

  logic                tick_s;
  logic                boundary_s;
  logic [3:0]          sel_code_s;
  logic                sel_dp_s;
  logic                sel_blank_s;
  logic [DIGITS-1:0]   an_sel_s;
  logic [DIGITS-1:0]   zero_from_s;
  seg_pat_t            pattern_s;

  // The divider only advances while enabled, so a disabled display also freezes the scan.
  assign tick_s     = enable && (div_r == DIV_LAST);
  assign boundary_s = tick_s && (idx_r == IDX_LAST);

  // slot divider and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= '0;
      idx_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
      idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
    end else if (enable) begin
      div_r <= div_r + DIV_W'(1);
    end else begin
      div_r <= div_r;
      idx_r <= idx_r;
    end
  end

  // pending/active double buffer; commits happen only on a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_code_r <= '0;
      active_dp_r   <= '0;
      pend_code_r   <= '0;
      pend_dp_r     <= '0;
      pend_r        <= 1'b0;
    end else if (load && boundary_s) begin
      active_code_r <= code_in;
      active_dp_r   <= dp_in;
      pend_r        <= 1'b0;
    end else if (load) begin
      pend_code_r <= code_in;
      pend_dp_r   <= dp_in;
      pend_r      <= 1'b1;
    end else if (boundary_s && pend_r) begin
      active_code_r <= pend_code_r;
      active_dp_r   <= pend_dp_r;
      pend_r        <= 1'b0;
    end else begin
      pend_r <= pend_r;
    end
  end

  // digit selection, anode one-hot and leading-zero run from the top digit down
  always_comb begin
    logic zero_run;
    zero_run    = 1'b1;
    sel_code_s  = 4'h0;
    sel_dp_s    = 1'b0;
    sel_blank_s = 1'b0;
    an_sel_s    = '1;
    zero_from_s = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run       = zero_run && (active_code_r[4*i +: 4] == 4'h0);
      zero_from_s[i] = zero_run;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_r == IDX_W'(i)) begin
        sel_code_s  = active_code_r[4*i +: 4];
        sel_dp_s    = active_dp_r[i];
        sel_blank_s = lz_blank && (i != 0) && zero_from_s[i];
        an_sel_s[i] = 1'b0;
      end else begin
        an_sel_s[i] = 1'b1;
      end
    end
  end

  seg7_decode u_decode (
    .code    (sel_code_s),
    .hex_en  (HEX_EN),
    .blank   (sel_blank_s),
    .pattern (pattern_s)
  );

  // registered display outputs, one cycle behind the index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= '1;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary_s;
      if (enable) begin
        an  <= an_sel_s;
        seg <= pattern_s;
        dp  <= ~sel_dp_s;
      end else begin
        an  <= '1;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised time-multiplexed driver for a common-anode multi-digit 7-segment display, used for the parking system's count and status readout.
- Holds a double-buffered digit value and scans one digit per refresh slot.
- Decodes 4-bit codes to active-low segments, with optional hex mode, per-digit decimal points and leading-zero blanking.
- New values are committed only at frame boundaries, so a displayed frame never mixes old and new digits.

Parameters:
- DIGITS, 4, number of digits scanned; DIGITS >= 2.
- SCAN_DIV, 100000, clock cycles per digit slot; SCAN_DIV >= 2. At 100 MHz this gives 1 ms per digit.
- HEX_MODE, 0. If 0, codes 10-15 are blank. If 1, codes 10-15 show A,b,C,d,E,F.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- code_in  input  4*DIGITS  digit codes; digit i is bits [4i+3:4i]; digit 0 is rightmost and least significant.
- dp_in  input  DIGITS  decimal point request per digit, 1 = lit.
- load  input  1  capture code_in/dp_in into the pending buffer.
- lz_blank  input  1  enable leading-zero suppression.
- enable  input  1  0 = display dark and scan frozen.
- an  output  DIGITS  anode selects, active-low, exactly one low while scanning.
- seg  output  7  {g,f,e,d,c,b,a}, active-low (0 = lit).
- dp  output  1  decimal point, active-low.
- frame_start  output  1  one-cycle pulse when the digit index wraps to 0.

Behaviour:
- Reset (async, rst_n=0) clears: divider=0, index=0, active and pending buffers=0, pend flag=0, an=all 1, seg=7'h7F, dp=1, frame_start=0.
- Divider:
  - Counts 0..SCAN_DIV-1 while enable=1.
  - tick = (divider==SCAN_DIV-1).
  - On tick the divider goes to 0 and index goes to index+1, or wraps from DIGITS-1 to 0.
- Frame boundary = tick while index==DIGITS-1. frame_start is registered high in the cycle after the boundary.
- Load:
  - load=1 captures code_in/dp_in into pending and sets pend.
  - On a frame boundary with pend=1, active<=pending and pend is cleared.
  - If load=1 on a boundary cycle, code_in/dp_in go straight to active and pend is cleared.
  - A later load before the boundary overwrites pending (last wins).
- Outputs are registered from the current index and active buffer, so they lag an index change by 1 cycle.
  - an[index]=0, all other anode bits 1.
  - seg = decode(active digit[index]); dp = ~active dp[index].
- Decode patterns (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111
- Leading-zero blanking (lz_blank=1): digit i>0 shows seg=blank when its code and every higher digit's code are 0. Digit 0 is never blanked. dp is unaffected by blanking.
- enable=0:
  - an=all 1, seg=7F, dp=1 from the next cycle.
  - Divider and index hold.
  - load still captures into pending, but no commit happens while disabled.
  - Scanning resumes from the held state when enable returns to 1.
- Reset mid-scan returns to index 0 immediately. Any uncommitted pending data is lost.

Decomposition:
- Shared include seg7_defs.vh holds the 16 segment pattern constants, the blank pattern, and the segment bit order.
- One sub-module, seg7_decode: a combinational 4-bit code plus hex_en plus blank input to a 7-bit active-low pattern. It is instantiated once on the selected digit.
- The scan divider, buffers and blanking logic stay in the top block.

Test Plan (DIGITS=4, SCAN_DIV=4):
- Release reset with enable=1 and no load. Expect an to cycle 1110→1101→1011→0111 every 4 clocks, seg=1000000 on every digit, and frame_start high 1 cycle every 16.
- load with code_in=16'h1234 mid-frame. Expect the old 0000 to be shown until the frame ends. After frame_start, digit3 shows seg=1111001 ("1") and digit0 shows 0011001 ("4").
- Two loads in one frame, 16'h1111 then 16'h0987. Expect the next frame to show 0987 only, and never 1111.
- lz_blank=1 with code_in=16'h0005. Expect digits 3..1 seg=1111111 and digit 0 seg=0010010. With code_in=16'h0000, digit 0 shows 1000000.
- HEX_MODE=0, code 4'hA on digit 0 → seg=1111111. HEX_MODE=1 → 0001000. With dp_in=4'b0001, dp=0 only while an=1110.
- Drop enable for 10 clocks mid-slot. Expect an=1111, seg=7F, and the index held. Re-enable and the same digit finishes its remaining slot. Asserting rst_n=0 asynchronously mid-slot forces an=1111 without waiting for a clock.
